// File: rtl/re_mitchell_mul.sv
// re_mitchell_mul: three-stage pipelined Mitchell logarithmic multiplier.
// Each operand arrives with its leading-one position from the upstream LOD.
// The block forms fixed-point log2 values, adds them, and applies a
// piecewise-linear antilog to produce an approximate 64-bit product.
// A single global stall moves every stage together under valid/ready flow control.

module re_mitchell_mul #(
  parameter int FRAC_W = 31,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [4:0]       k_a,
  input  logic [4:0]       k_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      p,
  output logic [TAG_W-1:0] out_tag
);

  // Low fraction bits beyond FRAC_W are forced to zero to model a coarser log.
  localparam int          DROP_W    = 31 - FRAC_W;
  localparam logic [30:0] FRAC_MASK = ~((31'(1) << DROP_W) - 31'(1));

  // Stage 1: captured operands.
  logic             r_s1Valid;
  logic [31:0]      r_s1A;
  logic [31:0]      r_s1B;
  logic [4:0]       r_s1Ka;
  logic [4:0]       r_s1Kb;
  logic             r_s1Z;
  logic [TAG_W-1:0] r_s1Tag;

  // Stage 2: summed log, split into integer exponent and mantissa.
  logic             r_s2Valid;
  logic [5:0]       r_s2Exp;
  logic [31:0]      r_s2Mant;
  logic             r_s2Z;
  logic [TAG_W-1:0] r_s2Tag;

  // Stage 3 holds only its valid here; its data lives directly in p/out_tag.
  logic             r_s3Valid;

  logic             w_adv;
  logic [30:0]      w_fracA;
  logic [30:0]      w_fracB;
  logic [31:0]      w_sum;
  logic [5:0]       w_exp;
  logic [31:0]      w_mant;
  logic [94:0]      w_prodWide;
  logic [63:0]      w_prod;

  // The whole pipe advances whenever the output slot is empty or being drained.
  // in_ready therefore depends on out_ready but never on in_valid.
  assign w_adv     = ~r_s3Valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3Valid;

  // Stage valids shift together on advance; reset empties the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
      r_s3Valid <= 1'b0;
    end else if (w_adv) begin
      r_s1Valid <= in_valid;
      r_s2Valid <= r_s1Valid;
      r_s3Valid <= r_s2Valid;
    end
  end

  // Capture operands, and flag zero operands because k cannot tell 0 from 1.
  always_ff @(posedge clk) begin
    if (w_adv && in_valid) begin
      r_s1A   <= a;
      r_s1B   <= b;
      r_s1Ka  <= k_a;
      r_s1Kb  <= k_b;
      r_s1Z   <= (a == 32'd0) | (b == 32'd0);
      r_s1Tag <= in_tag;
    end
  end

  // Log conversion: normalise each operand so its leading one sits at bit 31.
  // The bits below it form the Mitchell fraction. The fractions are then added,
  // and a carry out of the fraction bumps the exponent.
  always_comb begin
    w_fracA = 31'(r_s1A << (5'd31 - r_s1Ka)) & FRAC_MASK;
    w_fracB = 31'(r_s1B << (5'd31 - r_s1Kb)) & FRAC_MASK;
    w_sum   = {1'b0, w_fracA} + {1'b0, w_fracB};
    w_exp   = 6'(r_s1Ka) + 6'(r_s1Kb) + 6'(w_sum[31]);
    w_mant  = {1'b1, w_sum[30:0]};
  end

  // Register the summed log for the antilog stage.
  always_ff @(posedge clk) begin
    if (w_adv && r_s1Valid) begin
      r_s2Exp  <= w_exp;
      r_s2Mant <= w_mant;
      r_s2Z    <= r_s1Z;
      r_s2Tag  <= r_s1Tag;
    end
  end

  // Antilog: place the 1.f mantissa at the exponent, then drop the 31 fraction bits.
  // The largest mantissa shifted by 63 still fits in 95 bits, so the result fits in 64.
  always_comb begin
    w_prodWide = 95'(r_s2Mant) << r_s2Exp;
    w_prod     = r_s2Z ? 64'd0 : 64'(w_prodWide >> 31);
  end

  // Output register. It loads only for a real operation, so p and out_tag
  // keep their last value while bubbles pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p       <= 64'd0;
      out_tag <= '0;
    end else if (w_adv && r_s2Valid) begin
      p       <= w_prod;
      out_tag <= r_s2Tag;
    end
  end

endmodule
